// File: rtl/rr_mux_select_arbiter.sv
// rtl/rr_mux_select_arbiter.sv - round-robin owner select for a shared 1-bit 4:1 mux
module rr_mux_select_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_ONE = CW'(1);

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_grant, w_grant_nxt;
  logic [1:0]      r_sel, w_sel_nxt;
  logic            r_busy, w_busy_nxt;
  logic [CW-1:0]   r_hold_cnt, w_hold_nxt;
  logic [1:0]      r_last_owner, w_last_nxt;

  logic [1:0]      w_win;
  logic [1:0]      w_idx;
  logic            w_found;
  logic            w_owner_req;

  // Scan starts one past the last owner; the last owner itself is checked last,
  // so it wins only when nobody else is requesting.
  always_comb begin
    w_win   = r_last_owner;
    w_idx   = r_last_owner;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last_owner + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_owner_req = req[r_last_owner];

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_hold_nxt  = r_hold_cnt;
    w_last_nxt  = r_last_owner;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = OWNED;
          w_grant_nxt = 4'b0001 << w_win;
          w_sel_nxt   = w_win;
          w_busy_nxt  = 1'b1;
          w_hold_nxt  = HOLD_ONE;
          w_last_nxt  = w_win;
        end
      end
      OWNED: begin
        if (!w_owner_req) begin
          if (w_found) begin
            w_grant_nxt = 4'b0001 << w_win;
            w_sel_nxt   = w_win;
            w_hold_nxt  = HOLD_ONE;
            w_last_nxt  = w_win;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = 4'b0000;
            w_busy_nxt  = 1'b0;
            w_hold_nxt  = '0;
          end
        end else if (r_hold_cnt < HOLD_MAX) begin
          w_hold_nxt = r_hold_cnt + HOLD_ONE;
        end else if (w_win != r_last_owner) begin
          // Tenure exhausted and someone else waits: rotate.
          w_grant_nxt = 4'b0001 << w_win;
          w_sel_nxt   = w_win;
          w_hold_nxt  = HOLD_ONE;
          w_last_nxt  = w_win;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = 4'b0000;
        w_busy_nxt  = 1'b0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_grant      <= 4'b0000;
      r_sel        <= 2'b00;
      r_busy       <= 1'b0;
      r_hold_cnt   <= '0;
      r_last_owner <= 2'd3;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_sel        <= w_sel_nxt;
      r_busy       <= w_busy_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_last_owner <= w_last_nxt;
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign busy  = r_busy;

endmodule
